ibuf_fill_writer: RTL and testbench

Write-side controller for the 3-bank on-chip input buffer, the counterpart of the buffer-to-PE read controller. It accepts a column-major pixel stream from the off-chip loader, inserts zero halo according to the tile position type, and writes each tile column into the bank and address where the reader expects it. For column c and row r, the target is bank `c mod 3` at address `(c/3)*BUFFER_ROW + r`.

---
 rtl/ibuf_pkg.sv | 58 +++++
 rtl/ibuf_fill_writer_if.sv | 11 +
 rtl/ibuf_bank_addr_gen.sv | 72 +++++++
 rtl/ibuf_fill_writer.sv | 164 ++++++++++++++++
 tb/tb_ibuf_fill_writer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibuf_pkg.sv
// Shared definitions for the input-buffer fill (write) and read controllers:
// tile position encodings, bank indices, buffer geometry and pad-edge decode.
package ibuf_pkg;

  localparam logic [3:0] LEFT_UP        = 4'd0;
  localparam logic [3:0] UP             = 4'd1;
  localparam logic [3:0] RIGHT_UP       = 4'd2;
  localparam logic [3:0] LEFT           = 4'd3;
  localparam logic [3:0] MIDDLE         = 4'd4;
  localparam logic [3:0] RIGHT          = 4'd5;
  localparam logic [3:0] LEFT_DOWN      = 4'd6;
  localparam logic [3:0] DOWN           = 4'd7;
  localparam logic [3:0] RIGHT_DOWN     = 4'd8;
  localparam logic [3:0] ALL_PADDING    = 4'd9;
  localparam logic [3:0] ALL_NO_PADDING = 4'd10;

  localparam logic [1:0] Bank_0 = 2'd0;
  localparam logic [1:0] Bank_1 = 2'd1;
  localparam logic [1:0] Bank_2 = 2'd2;

  localparam int BUFFER_ROW_DEF = 34;
  localparam int BUFFER_COL_DEF = 36;

  typedef struct packed {
    logic top;
    logic bottom;
    logic left;
    logic right;
  } pad_edges_t;

  // Codes 11..15 are unassigned and decode to no padding.
  function automatic pad_edges_t decode_pad(input logic [3:0] tile_type);
    pad_edges_t e;
    e = '0;
    case (tile_type)
      LEFT_UP:     begin e.top = 1'b1;    e.left  = 1'b1; end
      UP:          begin e.top = 1'b1;                    end
      RIGHT_UP:    begin e.top = 1'b1;    e.right = 1'b1; end
      LEFT:        begin e.left = 1'b1;                   end
      RIGHT:       begin e.right = 1'b1;                  end
      LEFT_DOWN:   begin e.bottom = 1'b1; e.left  = 1'b1; end
      DOWN:        begin e.bottom = 1'b1;                 end
      RIGHT_DOWN:  begin e.bottom = 1'b1; e.right = 1'b1; end
      ALL_PADDING: e = '1;
      default:     e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] bank_onehot(input logic [1:0] bank);
    case (bank)
      Bank_0:  return 3'b001;
      Bank_1:  return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/ibuf_fill_writer_if.sv
// Column-major pixel stream from the off-chip loader into the fill writer.
interface ibuf_fill_writer_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ibuf_bank_addr_gen.sv
// Column-major position walker: row/column counters plus a rotating bank index
// and a column base that steps by BUFFER_ROW each time the bank wraps 2->0.
module ibuf_bank_addr_gen
  import ibuf_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int BUFFER_ROW = BUFFER_ROW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [6:0]        i_eff_rows,
  input  logic [6:0]        i_eff_cols,
  output logic [6:0]        o_row,
  output logic [6:0]        o_col,
  output logic [1:0]        o_bank,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_row,
  output logic              o_last_col,
  output logic              o_last
);

  logic [6:0]        r_row;
  logic [6:0]        r_col;
  logic [1:0]        r_bank;
  logic [ADDR_W-1:0] r_base;

  logic w_last_row;
  logic w_last_col;

  assign w_last_row = (r_row == i_eff_rows - 7'd1);
  assign w_last_col = (r_col == i_eff_cols - 7'd1);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_bank <= Bank_0;
      r_base <= '0;
    end else if (i_clear) begin
      r_row  <= '0;
      r_col  <= '0;
      r_bank <= Bank_0;
      r_base <= '0;
    end else if (i_advance) begin
      if (w_last_row) begin
        r_row <= '0;
        r_col <= r_col + 7'd1;
        if (r_bank == Bank_2) begin
          r_bank <= Bank_0;
          r_base <= r_base + ADDR_W'(BUFFER_ROW);
        end else begin
          r_bank <= r_bank + 2'd1;
        end
      end else begin
        r_row <= r_row + 7'd1;
      end
    end
  end

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_bank     = r_bank;
  assign o_addr     = r_base + ADDR_W'(r_row);
  assign o_last_row = w_last_row;
  assign o_last_col = w_last_col;
  assign o_last     = w_last_row && w_last_col;

endmodule

// File: rtl/ibuf_fill_writer.sv
// Input-buffer write controller: takes the loader stream, inserts zero halo on
// the tile's pad edges and writes each column to bank c%3, address (c/3)*BUFFER_ROW+r.
module ibuf_fill_writer
  import ibuf_pkg::*;
#(
  parameter int OFF_TO_ON_ADDRESS_SIZE = 13,
  parameter int DATA_WIDTH             = 64,
  parameter int BUFFER_ROW             = BUFFER_ROW_DEF,
  parameter int BUFFER_COL             = BUFFER_COL_DEF
) (
  input  logic                              clk,
  input  logic                              Ibuf_Fill_Ctrl_rst_n,
  input  logic                              start,
  input  logic [5:0]                        TILE_SIZE_row,
  input  logic [5:0]                        TILE_SIZE_col,
  input  logic [3:0]                        Type,
  input  logic                              buffer_sel,
  ibuf_fill_writer_if.slave                 stream,
  output logic                              Bank_we_0,
  output logic                              Bank_we_1,
  output logic                              Bank_we_2,
  output logic [OFF_TO_ON_ADDRESS_SIZE-1:0] Bank_addr_wr,
  output logic [DATA_WIDTH-1:0]             Bank_wdata,
  output logic                              Buffer_sel_wr,
  output logic                              busy,
  output logic                              Fill_finish,
  output logic                              Fill_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] LP_MAX_ROWS = 7'(BUFFER_ROW);
  localparam logic [6:0] LP_MAX_COLS = 7'(BUFFER_COL);

  logic [1:0]                        r_state;
  logic [6:0]                        r_eff_rows;
  logic [6:0]                        r_eff_cols;
  pad_edges_t                        r_pad;
  logic                              r_buffer_sel;
  logic [2:0]                        r_we;
  logic [OFF_TO_ON_ADDRESS_SIZE-1:0] r_addr;
  logic [DATA_WIDTH-1:0]             r_wdata;
  logic                              r_fill_finish;
  logic                              r_fill_err;

  logic [6:0]                        w_eff_rows;
  logic [6:0]                        w_eff_cols;
  logic                              w_size_ok;
  logic                              w_start_seen;
  logic                              w_start_ok;
  logic                              w_start_bad;
  logic                              w_fill;
  logic                              w_pad;
  logic                              w_advance;
  logic [6:0]                        w_row;
  logic [6:0]                        w_col;
  logic [1:0]                        w_bank;
  logic [OFF_TO_ON_ADDRESS_SIZE-1:0] w_addr;
  logic                              w_last_row;
  logic                              w_last_col;
  logic                              w_last;

  // Every padded tile carries a one-pixel halo on all four sides in its extent.
  assign w_eff_rows = (Type == ALL_NO_PADDING) ? {1'b0, TILE_SIZE_row}
                                               : {1'b0, TILE_SIZE_row} + 7'd2;
  assign w_eff_cols = (Type == ALL_NO_PADDING) ? {1'b0, TILE_SIZE_col}
                                               : {1'b0, TILE_SIZE_col} + 7'd2;

  assign w_size_ok    = (TILE_SIZE_row != 6'd0) && (TILE_SIZE_col != 6'd0) &&
                        (w_eff_rows <= LP_MAX_ROWS) && (w_eff_cols <= LP_MAX_COLS);
  assign w_start_seen = start && (r_state != S_FILL);
  assign w_start_ok   = w_start_seen && w_size_ok;
  assign w_start_bad  = w_start_seen && !w_size_ok;

  assign w_fill    = (r_state == S_FILL);
  assign w_pad     = (r_pad.top    && (w_row == 7'd0)) ||
                     (r_pad.bottom && w_last_row)      ||
                     (r_pad.left   && (w_col == 7'd0)) ||
                     (r_pad.right  && w_last_col);
  // Pad positions advance on their own; data positions wait for the stream.
  assign w_advance = w_fill && (w_pad || stream.in_valid);

  assign stream.in_ready = w_fill && !w_pad;

  ibuf_bank_addr_gen #(
    .ADDR_W     (OFF_TO_ON_ADDRESS_SIZE),
    .BUFFER_ROW (BUFFER_ROW)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (Ibuf_Fill_Ctrl_rst_n),
    .i_clear    (w_start_ok),
    .i_advance  (w_advance),
    .i_eff_rows (r_eff_rows),
    .i_eff_cols (r_eff_cols),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_bank     (w_bank),
    .o_addr     (w_addr),
    .o_last_row (w_last_row),
    .o_last_col (w_last_col),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge Ibuf_Fill_Ctrl_rst_n) begin
    if (!Ibuf_Fill_Ctrl_rst_n) begin
      r_state       <= S_IDLE;
      r_eff_rows    <= '0;
      r_eff_cols    <= '0;
      r_pad         <= '0;
      r_buffer_sel  <= 1'b0;
      r_we          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_fill_finish <= 1'b0;
      r_fill_err    <= 1'b0;
    end else begin
      r_we       <= '0;
      r_fill_err <= w_start_bad;

      if (w_start_ok) begin
        r_eff_rows   <= w_eff_rows;
        r_eff_cols   <= w_eff_cols;
        r_pad        <= decode_pad(Type);
        r_buffer_sel <= buffer_sel;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_ok) r_state <= S_FILL;
        end
        S_FILL: begin
          if (w_advance) begin
            r_we    <= bank_onehot(w_bank);
            r_addr  <= w_addr;
            r_wdata <= w_pad ? '0 : stream.in_data;
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_start_ok) begin
            r_state       <= S_FILL;
            r_fill_finish <= 1'b0;
          end else begin
            r_fill_finish <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Bank_we_0     = r_we[0];
  assign Bank_we_1     = r_we[1];
  assign Bank_we_2     = r_we[2];
  assign Bank_addr_wr  = r_addr;
  assign Bank_wdata    = r_wdata;
  assign Buffer_sel_wr = r_buffer_sel;
  assign busy          = w_fill;
  assign Fill_finish   = r_fill_finish;
  assign Fill_err      = r_fill_err;

endmodule

// File: tb/tb_ibuf_fill_writer.sv
// Bench for ibuf_fill_writer: table of tile vectors plus a reset-abort sequence;
// expected bank writes come from a positional model held in a scoreboard queue.
module tb_ibuf_fill_writer;
  import ibuf_pkg::*;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int BR = 34;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [5:0]    tile_rows;
  logic [5:0]    tile_cols;
  logic [3:0]    tile_type;
  logic          buffer_sel;
  logic          we0, we1, we2;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          sel_wr, busy, fin, err;

  always #5 clk = ~clk;

  ibuf_fill_writer_if #(.DATA_WIDTH(DW)) s_if ();

  ibuf_fill_writer #(
    .OFF_TO_ON_ADDRESS_SIZE (AW),
    .DATA_WIDTH             (DW),
    .BUFFER_ROW             (34),
    .BUFFER_COL             (36)
  ) dut (
    .clk                  (clk),
    .Ibuf_Fill_Ctrl_rst_n (rst_n),
    .start                (start),
    .TILE_SIZE_row        (tile_rows),
    .TILE_SIZE_col        (tile_cols),
    .Type                 (tile_type),
    .buffer_sel           (buffer_sel),
    .stream               (s_if),
    .Bank_we_0            (we0),
    .Bank_we_1            (we1),
    .Bank_we_2            (we2),
    .Bank_addr_wr         (addr),
    .Bank_wdata           (wdata),
    .Buffer_sel_wr        (sel_wr),
    .busy                 (busy),
    .Fill_finish          (fin),
    .Fill_err             (err)
  );

  typedef struct {
    logic [2:0]    we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] ttype;
    logic [5:0] rows;
    logic [5:0] cols;
    logic       toggle;
    logic       bsel;
    int         exp_writes;
    int         exp_accepts;
    logic       exp_err;
    logic       chk_ready;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[11];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_wr = 0, n_err = 0, n_busy = 0, n_ready_drop = 0, last_we_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pad_at(input logic [3:0] t, input int r, input int c,
                                  input int er, input int ec);
    logic top, bot, lf, rt;
    top = 1'b0; bot = 1'b0; lf = 1'b0; rt = 1'b0;
    case (t)
      4'd0: begin top = 1'b1; lf = 1'b1; end
      4'd1: top = 1'b1;
      4'd2: begin top = 1'b1; rt = 1'b1; end
      4'd3: lf = 1'b1;
      4'd5: rt = 1'b1;
      4'd6: begin bot = 1'b1; lf = 1'b1; end
      4'd7: bot = 1'b1;
      4'd8: begin bot = 1'b1; rt = 1'b1; end
      4'd9: begin top = 1'b1; bot = 1'b1; lf = 1'b1; rt = 1'b1; end
      default: ;
    endcase
    return (top && r == 0) || (bot && r == er - 1) || (lf && c == 0) || (rt && c == ec - 1);
  endfunction

  // Expected writes straight from the placement formula: bank c%3, addr (c/3)*BR + r.
  task automatic push_model(input vec_t v);
    int er, ec, k;
    wr_t w;
    er = (v.ttype == 4'd10) ? int'(v.rows) : int'(v.rows) + 2;
    ec = (v.ttype == 4'd10) ? int'(v.cols) : int'(v.cols) + 2;
    k  = 0;
    for (int c = 0; c < ec; c++) begin
      for (int r = 0; r < er; r++) begin
        w.we   = 3'b001 << (c % 3);
        w.addr = AW'((c / 3) * BR + r);
        if (pad_at(v.ttype, r, c, er, ec)) begin
          w.data = '0;
        end else begin
          k++;
          w.data = DW'(k);
        end
        exp_q.push_back(w);
      end
    end
  endtask

  always @(negedge clk) begin
    if (err) n_err++;
    if (busy) n_busy++;
    if (busy && !s_if.in_ready) n_ready_drop++;
    if ({we2, we1, we0} != 3'b000) begin
      n_wr++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {61'd0, we2, we1, we0}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_bank_we", {61'd0, we2, we1, we0}, {61'd0, mon_e.we});
        check("wr_addr", {51'd0, addr}, {51'd0, mon_e.addr});
        check("wr_data", wdata, mon_e.data);
      end
    end
  end

  task automatic run_tile(input vec_t v, input string tag);
    int   word, n_acc, er, ec;
    logic done;
    er = (v.ttype == 4'd10) ? int'(v.rows) : int'(v.rows) + 2;
    ec = (v.ttype == 4'd10) ? int'(v.cols) : int'(v.cols) + 2;
    if (!v.exp_err) push_model(v);
    @(posedge clk); #1;
    n_wr = 0; n_err = 0; n_busy = 0; n_ready_drop = 0; n_acc = 0;
    tile_type  = v.ttype;
    tile_rows  = v.rows;
    tile_cols  = v.cols;
    buffer_sel = v.bsel;
    start      = 1'b1;
    s_if.in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.exp_err) begin
      repeat (6) @(negedge clk);
      #1;
      check({tag, "_busy_cycles"}, 64'(n_busy), 64'd0);
    end else begin
      word = 1;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
        s_if.in_valid = (v.toggle ? (i % 2 == 0) : 1'b1) && (word <= v.exp_accepts);
        s_if.in_data  = DW'(word);
        @(negedge clk);
        if (i == 0) begin
          check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
          check({tag, "_finish_clear"}, {63'd0, fin}, 64'd0);
          check({tag, "_first_ready"}, {63'd0, s_if.in_ready},
                {63'd0, !pad_at(v.ttype, 0, 0, er, ec)});
        end
        if (s_if.in_valid && s_if.in_ready) begin
          n_acc++;
          word++;
        end
        if (fin) done = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      s_if.in_valid = 1'b0;
      #1;
      check({tag, "_finish_seen"}, {63'd0, done}, 64'd1);
      check({tag, "_finish_latency"}, 64'(cyc - last_we_cyc), 64'd1);
      check({tag, "_accepts"}, 64'(n_acc), 64'(v.exp_accepts));
      check({tag, "_sel_wr"}, {63'd0, sel_wr}, {63'd0, v.bsel});
      if (v.chk_ready) check({tag, "_ready_drops"}, 64'(n_ready_drop), 64'd0);
    end
    check({tag, "_writes"}, 64'(n_wr), 64'(v.exp_writes));
    check({tag, "_err_pulses"}, 64'(n_err), {63'd0, v.exp_err});
    check({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int   word;
    vec_t rv;

    //          type   rows   cols  tog   bsel  wr  acc  err   rdy
    vecs[0]  = '{4'd10, 6'd2,  6'd4,  1'b0, 1'b0, 8,   8,   1'b0, 1'b0};
    vecs[1]  = '{4'd9,  6'd2,  6'd2,  1'b0, 1'b1, 16,  4,   1'b0, 1'b0};
    vecs[2]  = '{4'd4,  6'd2,  6'd2,  1'b0, 1'b0, 16,  16,  1'b0, 1'b1};
    vecs[3]  = '{4'd10, 6'd2,  6'd4,  1'b1, 1'b1, 8,   8,   1'b0, 1'b0};
    vecs[4]  = '{4'd0,  6'd3,  6'd2,  1'b1, 1'b0, 20,  12,  1'b0, 1'b0};
    vecs[5]  = '{4'd8,  6'd2,  6'd3,  1'b0, 1'b1, 20,  12,  1'b0, 1'b0};
    vecs[6]  = '{4'd10, 6'd40, 6'd4,  1'b0, 1'b0, 0,   0,   1'b1, 1'b0};
    vecs[7]  = '{4'd4,  6'd2,  6'd0,  1'b0, 1'b0, 0,   0,   1'b1, 1'b0};
    vecs[8]  = '{4'd4,  6'd33, 6'd1,  1'b0, 1'b0, 0,   0,   1'b1, 1'b0};
    vecs[9]  = '{4'd10, 6'd1,  6'd36, 1'b0, 1'b0, 36,  36,  1'b0, 1'b0};
    vecs[10] = '{4'd1,  6'd32, 6'd1,  1'b0, 1'b1, 102, 99,  1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; tile_rows = '0; tile_cols = '0; tile_type = '0;
    buffer_sel = 1'b0; s_if.in_valid = 1'b0; s_if.in_data = '0;
    #3;
    check("rst_we", {61'd0, we2, we1, we0}, 64'd0);
    check("rst_addr", {51'd0, addr}, 64'd0);
    check("rst_data", wdata, 64'd0);
    check("rst_flags", {59'd0, busy, fin, err, sel_wr, s_if.in_ready}, 64'd0);
    #19 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_tile(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-fill: abort after three writes, then restart from bank0 @0.
    rv = vecs[0];
    push_model(rv);
    @(posedge clk); #1;
    n_wr = 0;
    tile_type = rv.ttype; tile_rows = rv.rows; tile_cols = rv.cols;
    buffer_sel = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    word = 1;
    for (int i = 0; i < 50 && n_wr < 3; i++) begin
      s_if.in_valid = 1'b1;
      s_if.in_data  = DW'(word);
      @(negedge clk);
      if (s_if.in_ready) word++;
      #1;
      if (n_wr < 3) begin
        @(posedge clk); #1;
      end
    end
    check("abort_three_writes", 64'(n_wr), 64'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_we", {61'd0, we2, we1, we0}, 64'd0);
    check("abort_addr", {51'd0, addr}, 64'd0);
    check("abort_data", wdata, 64'd0);
    check("abort_flags", {59'd0, busy, fin, err, sel_wr, s_if.in_ready}, 64'd0);
    exp_q.delete();
    s_if.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    rv.bsel = 1'b1;
    run_tile(rv, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
